openddr_axi_master: RTL and testbench

AXI4 initiator that turns single-entry user commands into AXI INCR bursts toward an AXI responder. It is the partner of the controller's AXI slave port and serves as the host-side traffic engine and the bring-up master for the DDR controller. It keeps one transaction outstanding at a time and passes write and read data straight through with handshakes. It returns a one-cycle completion pulse carrying the merged response.

---
 rtl/openddr_axi_master_if.sv | 75 +++++++
 rtl/openddr_axi_master.sv | 144 ++++++++++++++
 tb/tb_openddr_axi_master.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/openddr_axi_master_if.sv
// rtl/openddr_axi_master_if.sv - command, user data, completion and AXI4 master bundle
// master: the initiator's view; slave: the command issuer / AXI responder view.
interface openddr_axi_master_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 40,
   parameter int ID_WIDTH   = 12
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]            cmd_len;
   logic [ID_WIDTH-1:0]   cmd_id;

   logic [DATA_WIDTH-1:0] usr_wdata;
   logic [STRB_WIDTH-1:0] usr_wstrb;
   logic                  usr_wvalid, usr_wready;
   logic [DATA_WIDTH-1:0] usr_rdata;
   logic [1:0]            usr_rresp;
   logic                  usr_rlast, usr_rvalid;

   logic                  done_valid, done_write, err_rlast;
   logic [ID_WIDTH-1:0]   done_id;
   logic [1:0]            done_resp;

   logic [ID_WIDTH-1:0]   axi_awid, axi_arid, axi_bid, axi_rid;
   logic [ADDR_WIDTH-1:0] axi_awaddr, axi_araddr;
   logic [7:0]            axi_awlen, axi_arlen;
   logic [2:0]            axi_awsize, axi_arsize;
   logic [1:0]            axi_awburst, axi_arburst, axi_bresp, axi_rresp;
   logic                  axi_awvalid, axi_awready, axi_arvalid, axi_arready;
   logic [DATA_WIDTH-1:0] axi_wdata, axi_rdata;
   logic [STRB_WIDTH-1:0] axi_wstrb;
   logic                  axi_wlast, axi_wvalid, axi_wready;
   logic                  axi_bvalid, axi_bready;
   logic                  axi_rlast, axi_rvalid, axi_rready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
      output cmd_ready,
      input  usr_wdata, usr_wstrb, usr_wvalid,
      output usr_wready,
      output usr_rdata, usr_rresp, usr_rlast, usr_rvalid,
      output done_valid, done_id, done_resp, done_write, err_rlast,
      output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      input  axi_awready,
      output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      input  axi_wready,
      input  axi_bid, axi_bresp, axi_bvalid,
      output axi_bready,
      output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
      input  axi_arready,
      input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      output axi_rready
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
      input  cmd_ready,
      output usr_wdata, usr_wstrb, usr_wvalid,
      input  usr_wready,
      input  usr_rdata, usr_rresp, usr_rlast, usr_rvalid,
      input  done_valid, done_id, done_resp, done_write, err_rlast,
      input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
      output axi_awready,
      input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      output axi_wready,
      output axi_bid, axi_bresp, axi_bvalid,
      input  axi_bready,
      input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
      output axi_arready,
      output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      input  axi_rready
   );
endinterface

// File: rtl/openddr_axi_master.sv
// rtl/openddr_axi_master.sv - single-outstanding AXI4 INCR burst initiator
// One command in flight; W and R data pass straight through, completion is a one-cycle pulse.
module openddr_axi_master #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 40,
   parameter int ID_WIDTH   = 12
) (
   input logic                  clk,
   input logic                  rst_n,
   openddr_axi_master_if.master bus
);
   localparam int         STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [2:0] AXSIZE     = 3'($clog2(STRB_WIDTH));

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
   state_t state, state_nxt;

   logic                  rst_done;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q, beat_cnt;
   logic [ID_WIDTH-1:0]   id_q;
   logic                  write_q, err_q;
   logic [1:0]            bresp_q, resp_acc;
   logic                  accept, last_beat, w_hs, r_hs, r_end, r_err;

   // rst_done keeps cmd_ready low while reset is held, even though state is already IDLE
   assign accept    = (state == IDLE) && rst_done && bus.cmd_valid;
   assign last_beat = (beat_cnt == len_q);
   assign w_hs      = (state == W) && bus.usr_wvalid && bus.axi_wready;
   assign r_hs      = (state == R) && bus.axi_rvalid;
   assign r_end     = bus.axi_rlast || last_beat;
   assign r_err     = bus.axi_rlast != last_beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = bus.cmd_write ? AW : AR;
         AW:   if (bus.axi_awready) state_nxt = W;
         W:    if (w_hs && last_beat) state_nxt = B;
         B:    if (bus.axi_bvalid) state_nxt = DONE;
         AR:   if (bus.axi_arready) state_nxt = R;
         R:    if (r_hs && r_end) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         id_q     <= '0;
         write_q  <= 1'b0;
         beat_cnt <= '0;
         bresp_q  <= '0;
         resp_acc <= '0;
         err_q    <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (accept) begin
            addr_q   <= bus.cmd_addr;
            len_q    <= bus.cmd_len;
            id_q     <= bus.cmd_id;
            write_q  <= bus.cmd_write;
            bresp_q  <= '0;
            resp_acc <= '0;
         end
         if (w_hs) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
         // Read burst ends on the earlier of RLAST or the expected beat count
         if (r_hs) begin
            beat_cnt <= r_end ? 8'd0 : beat_cnt + 8'd1;
            if (bus.axi_rresp > resp_acc) resp_acc <= bus.axi_rresp;
            if (r_err) err_q <= 1'b1;
         end
         if (state == B && bus.axi_bvalid) bresp_q <= bus.axi_bresp;
      end
   end

   assign bus.axi_awid    = id_q;
   assign bus.axi_awaddr  = addr_q;
   assign bus.axi_awlen   = len_q;
   assign bus.axi_awsize  = AXSIZE;
   assign bus.axi_awburst = 2'b01;
   assign bus.axi_arid    = id_q;
   assign bus.axi_araddr  = addr_q;
   assign bus.axi_arlen   = len_q;
   assign bus.axi_arsize  = AXSIZE;
   assign bus.axi_arburst = 2'b01;
   assign bus.err_rlast   = err_q;

   always_comb begin
      bus.cmd_ready   = 1'b0;
      bus.axi_awvalid = 1'b0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_wdata   = '0;
      bus.axi_wstrb   = '0;
      bus.axi_wlast   = 1'b0;
      bus.usr_wready  = 1'b0;
      bus.axi_bready  = 1'b0;
      bus.axi_arvalid = 1'b0;
      bus.axi_rready  = 1'b0;
      bus.usr_rvalid  = 1'b0;
      bus.usr_rdata   = '0;
      bus.usr_rresp   = '0;
      bus.usr_rlast   = 1'b0;
      bus.done_valid  = 1'b0;
      bus.done_id     = '0;
      bus.done_resp   = '0;
      bus.done_write  = 1'b0;
      case (state)
         IDLE: bus.cmd_ready = rst_done;
         AW:   bus.axi_awvalid = 1'b1;
         W: begin
            bus.axi_wvalid = bus.usr_wvalid;
            bus.axi_wdata  = bus.usr_wdata;
            bus.axi_wstrb  = bus.usr_wstrb;
            bus.axi_wlast  = last_beat;
            bus.usr_wready = bus.axi_wready;
         end
         B:  bus.axi_bready = 1'b1;
         AR: bus.axi_arvalid = 1'b1;
         R: begin
            bus.axi_rready = 1'b1;
            bus.usr_rvalid = bus.axi_rvalid;
            bus.usr_rdata  = bus.axi_rdata;
            bus.usr_rresp  = bus.axi_rresp;
            bus.usr_rlast  = bus.axi_rvalid && r_end;
         end
         DONE: begin
            bus.done_valid = 1'b1;
            bus.done_id    = id_q;
            bus.done_write = write_q;
            bus.done_resp  = write_q ? bresp_q : resp_acc;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_openddr_axi_master.sv
// tb/tb_openddr_axi_master.sv - directed bench for openddr_axi_master
// The bench plays both command issuer and AXI responder, cycle by cycle.
module tb_openddr_axi_master;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   openddr_axi_master_if #(.DATA_WIDTH(64), .ADDR_WIDTH(40), .ID_WIDTH(12)) bus ();

   openddr_axi_master #(.DATA_WIDTH(64), .ADDR_WIDTH(40), .ID_WIDTH(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
      bus.usr_wdata = '0; bus.usr_wstrb = '0; bus.usr_wvalid = 0;
      bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_arready = 0;
      bus.axi_bid = '0; bus.axi_bresp = '0; bus.axi_bvalid = 0;
      bus.axi_rid = '0; bus.axi_rdata = '0; bus.axi_rresp = '0; bus.axi_rlast = 0; bus.axi_rvalid = 0;
   endtask

   task automatic issue(input bit wr, input logic [39:0] addr, input logic [11:0] id, input int len, input string tag);
      bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = len[7:0]; bus.cmd_id = id;
      #1 check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
      tick;
      bus.cmd_valid = 0;
   endtask

   task automatic finish_txn(input bit wr, input logic [11:0] id, input logic [1:0] resp, input string tag);
      #1;
      check({tag, "_done_valid"}, 64'(bus.done_valid), 64'd1);
      check({tag, "_done_id"}, 64'(bus.done_id), 64'(id));
      check({tag, "_done_resp"}, 64'(bus.done_resp), 64'(resp));
      check({tag, "_done_write"}, 64'(bus.done_write), 64'(wr));
      tick;
      check({tag, "_done_pulse_end"}, {bus.done_valid, bus.cmd_ready}, 64'b01);
   endtask

   task automatic do_write(input logic [39:0] addr, input logic [11:0] id, input int len,
                           input logic [1:0] bresp, input bit rnd, input string tag);
      int beats = 0, lasts = 0, last_idx = -1, bad = 0, cyc = 0;
      logic [63:0] wd;
      logic [7:0]  ws;
      issue(1'b1, addr, id, len, tag);
      bus.axi_awready = 1;
      #1 check({tag, "_aw"}, {bus.axi_awvalid, bus.axi_awaddr, bus.axi_awlen, bus.axi_awid, bus.axi_awsize, bus.axi_awburst},
               {1'b1, addr, len[7:0], id, 3'd3, 2'b01});
      tick;
      bus.axi_awready = 0;
      bus.axi_wready  = 1;
      while (beats <= len && cyc < 3000) begin
         wd = {32'hA5A5_0000, 32'(beats)};
         ws = 8'hFF ^ 8'(beats);
         bus.usr_wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.usr_wdata  = wd;
         bus.usr_wstrb  = ws;
         #1;
         if (bus.axi_awvalid || bus.usr_wready !== bus.axi_wready || bus.axi_wvalid !== bus.usr_wvalid) bad++;
         if (bus.axi_wvalid && bus.axi_wready) begin
            if (bus.axi_wdata !== wd || bus.axi_wstrb !== ws) bad++;
            if (bus.axi_wlast) begin lasts++; last_idx = beats; end
            beats++;
         end
         tick;
         cyc++;
      end
      bus.usr_wvalid = 0; bus.axi_wready = 0;
      check({tag, "_w_beats"}, 64'(beats), 64'(len + 1));
      check({tag, "_wlast_count"}, 64'(lasts), 64'd1);
      check({tag, "_wlast_idx"}, 64'(last_idx), 64'(len));
      check({tag, "_w_pass_bad"}, 64'(bad), 64'd0);
      bus.axi_bvalid = 1; bus.axi_bresp = bresp; bus.axi_bid = id;
      #1 check({tag, "_bready"}, 64'(bus.axi_bready), 64'd1);
      tick;
      bus.axi_bvalid = 0; bus.axi_bresp = 0;
      finish_txn(1'b1, id, bresp, tag);
   endtask

   task automatic do_read(input logic [39:0] addr, input logic [11:0] id, input int len, input int ar_delay,
                          input bit toggle, input int last_at, input int resp_beat, input logic [1:0] resp_val,
                          input logic [1:0] exp_resp, input bit exp_err, input string tag);
      int held = 0, k = 0, cyc = 0, bad = 0, lasts = 0;
      int end_k = (last_at < len) ? last_at : len;
      issue(1'b0, addr, id, len, tag);
      for (int c = 0; c <= ar_delay; c++) begin
         bus.axi_arready = (c == ar_delay);
         #1;
         if ({bus.axi_arvalid, bus.axi_araddr, bus.axi_arlen, bus.axi_arid, bus.axi_arsize, bus.axi_arburst}
             === {1'b1, addr, len[7:0], id, 3'd3, 2'b01}) held++;
         tick;
      end
      bus.axi_arready = 0;
      check({tag, "_ar_held"}, 64'(held), 64'(ar_delay + 1));
      while (k <= end_k && cyc < 400) begin
         bus.axi_rvalid = toggle ? 1'(cyc % 2) : 1'b1;
         bus.axi_rdata  = {32'hC0DE_0000, 32'(k)};
         bus.axi_rresp  = (k == resp_beat) ? resp_val : 2'b00;
         bus.axi_rlast  = (k == last_at);
         bus.axi_rid    = id;
         #1;
         if (bus.axi_rready !== 1'b1 || bus.usr_rvalid !== bus.axi_rvalid) bad++;
         if (bus.axi_rvalid) begin
            if (bus.usr_rdata !== {32'hC0DE_0000, 32'(k)} || bus.usr_rresp !== bus.axi_rresp) bad++;
            if (bus.usr_rlast) lasts++;
            if (bus.usr_rlast !== (k == end_k)) bad++;
            k++;
         end
         tick;
         cyc++;
      end
      bus.axi_rvalid = 0; bus.axi_rlast = 0; bus.axi_rresp = 0;
      check({tag, "_r_beats"}, 64'(k), 64'(end_k + 1));
      check({tag, "_r_pass_bad"}, 64'(bad), 64'd0);
      check({tag, "_usr_rlast_count"}, 64'(lasts), 64'd1);
      #1 check({tag, "_err_rlast"}, 64'(bus.err_rlast), 64'(exp_err));
      finish_txn(1'b0, id, exp_resp, tag);
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      tick;
      tick;
      check("rst_ready_valids", {bus.cmd_ready, bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_bready,
                                 bus.axi_rready, bus.usr_wready, bus.usr_rvalid, bus.done_valid, bus.err_rlast}, 64'd0);
      check("rst_addr_id_len", {bus.axi_awaddr, bus.axi_arid, bus.axi_arlen}, 64'd0);
      rst_n = 1'b1;
      tick;
      check("rst_release_ready", 64'(bus.cmd_ready), 64'd1);

      do_write(40'h10_00, 12'h005, 3, 2'b00, 1'b0, "wr_len3");
      do_read(40'h20_0040, 12'h0A1, 7, 3, 1'b1, 7, 5, 2'b01, 2'b01, 1'b0, "rd_len7");
      do_read(40'h30_0000, 12'h0B2, 0, 0, 1'b0, 0, 0, 2'b10, 2'b10, 1'b0, "rd_len0_slverr");
      do_read(40'h40_0000, 12'h0C3, 3, 1, 1'b0, 1, 9, 2'b00, 2'b00, 1'b1, "rd_early_rlast");
      do_write(40'h50_0000, 12'hFFF, 255, 2'b11, 1'b1, "wr_len255");
      check("err_rlast_sticky", 64'(bus.err_rlast), 64'd1);

      issue(1'b1, 40'h60_0000, 12'h006, 3, "rst_mid");
      bus.axi_awready = 1;
      tick;
      bus.axi_awready = 0; bus.axi_wready = 1; bus.usr_wvalid = 1;
      tick;
      #1 rst_n = 1'b0;
      #1 check("rst_mid_async", {bus.cmd_ready, bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_bready,
                                 bus.axi_rready, bus.usr_wready, bus.usr_rvalid, bus.done_valid, bus.err_rlast}, 64'd0);
      idle_inputs();
      tick;
      rst_n = 1'b1;
      tick;
      check("rst_mid_ready", 64'(bus.cmd_ready), 64'd1);
      do_read(40'h70_0000, 12'h007, 0, 0, 1'b0, 0, 0, 2'b00, 2'b00, 1'b0, "rd_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
